cgra_multiport_regfile: RTL
===========================

// Module: cgra_multiport_regfile
// PURPOSE
//  Parametrised multi-port register file for CGRA tiles. It generalises the fixed per-type RF instances to any
//  width, depth and port count, and adds:
//  - per-entry valid bits;
//  - deterministic write-collision priority;
//  - optional write-to-read bypass;
//  - a sequential bulk-clear engine.
//  It sits in tile data/predicate/config storage, between the crossbar writeback and FU operand fetch.
// PARAMETERS
//  DATA_W     34   entry width (CGRAData_32_1_1 packed = 32+1+1)
//  NREGS      100  number of entries (need not be a power of 2)
//  RD_PORTS   4    read port count
//  WR_PORTS   4    write port count
//  BYPASS     0    1: a read of an address written this cycle returns the winning wdata combinationally
//  CONST_ZERO 0    1: entry 0 always reads 0 with rvalid=1; writes to entry 0 are dropped
//  ADDR_W     $clog2(NREGS) (derived, localparam)
// PORTS
//  clk          in   1                  clock, all state on posedge
//  reset        in   1                  asynchronous, active-low reset
//  raddr        in   RD_PORTS*ADDR_W    read addresses, port i at [i*ADDR_W +: ADDR_W]
//  rdata        out  RD_PORTS*DATA_W    read data, combinational
//  rvalid       out  RD_PORTS           entry at raddr[i] holds written data
//  waddr        in   WR_PORTS*ADDR_W    write addresses
//  wdata        in   WR_PORTS*DATA_W    write data
//  wen          in   WR_PORTS           write enables
//  clr_req      in   1                  start bulk clear (level sampled in IDLE)
//  clr_busy     out  1                  clear in progress; upstream must stall writes
//  clr_done     out  1                  1-cycle pulse when clear completes
//  wr_conflict  out  1                  registered pulse: >=2 enabled ports hit one address last cycle
// BEHAVIOUR
//  Reset (reset=0, async):
//  - Clears all valid bits, the FSM (to IDLE), the sweep pointer, clr_busy, clr_done and wr_conflict.
//  - The data array is not reset. With all valid bits clear, every rdata reads 0 and every rvalid is 0.
//  Read (0-cycle latency):
//  - rdata[i] = valid[a] ? regs[a] : 0, and rvalid[i] = valid[a], where a = raddr[i].
//  - a >= NREGS: rdata=0, rvalid=0.
//  - With BYPASS=1 and a matching enabled, in-range, accepted write this cycle:
//    rdata = winning wdata, rvalid = 1.
//  Write (visible on the next posedge):
//  - An accepted write sets regs[waddr] <= wdata and valid[waddr] <= 1.
//  - A write is dropped when waddr >= NREGS, when CONST_ZERO=1 and waddr==0, or when the FSM is not IDLE.
//  - Collision: among enabled ports with equal waddr, the highest port index wins.
//  - wr_conflict <= 1 for one cycle whenever any collision occurs, including collisions whose writes are dropped.
//  Clear FSM, states IDLE -> SWEEP -> DONE -> IDLE:
//  - IDLE: when clr_req=1, go to SWEEP with ptr=0.
//  - SWEEP: each cycle valid[ptr] <= 0 and ptr++. After ptr==NREGS-1, go to DONE. clr_busy=1.
//    User writes are ignored.
//  - DONE: clr_done=1 for one cycle, clr_busy=0, user writes are still ignored. Then go to IDLE.
//  - Latency: clr_done is asserted NREGS+1 cycles after the clr_req sample edge.
//  - Reads during SWEEP reflect the partial clear: entries below ptr read invalid.
//    Bypass is disabled while the FSM is not IDLE.
//  - clr_req while SWEEP or DONE is ignored. Async reset mid-SWEEP aborts to IDLE with all valid bits clear.
// STRUCTURE
//  Package cgra_rf_pkg holds:
//  - the CGRAData_32_1_1, CGRAData_1_1 and CGRAConfig_6_4_6_8 typedefs;
//  - enum rf_clr_state_e {IDLE, SWEEP, DONE};
//  - the $clog2 helper.
//  One sub-module, cgra_rf_wr_resolve. It takes waddr, wen and the accept condition and produces:
//  - a per-port effective-write mask, with losers and out-of-range writes masked;
//  - the conflict flag;
//  - the per-read-port bypass select.
//  The top holds the array, the valid vector, the FSM and the read muxes.
// TESTING
//  1. After reset, read addresses 0..NREGS-1 -> all rdata=0, rvalid=0. clr_busy, clr_done and wr_conflict are 0.
//  2. Port0 writes 0x155 to addr 7. Next cycle raddr0=7 -> rdata=0x155, rvalid=1. raddr1=8 -> rvalid=0.
//  3. Ports 1 and 3 both write addr 5, with 0xA and 0xB -> regs[5]=0xB and wr_conflict=1 for exactly 1 cycle.
//  4. BYPASS=1: write 0x3C to addr 9 while raddr2=9 in the same cycle -> rdata[2]=0x3C, rvalid[2]=1 that cycle.
//  5. Fill addresses 0..99, then pulse clr_req:
//     - clr_busy stays high 100 cycles and clr_done pulses at cycle 101;
//     - writes in that window are dropped;
//     - all rvalid=0 afterwards.
//     Repeat with reset asserted mid-sweep -> FSM is IDLE and all rvalid=0.
//  6. Out of range and constant zero:
//     - NREGS=100: write to addr 120 is dropped, and a read of 120 gives rdata=0, rvalid=0.
//     - CONST_ZERO=1: write 0xFF to addr 0, then read 0 -> rdata=0, rvalid=1.

Source files
------------

// File: rtl/cgra_rf_pkg.sv
// Shared types and helpers for the CGRA tile register files.
package cgra_rf_pkg;

   typedef struct packed {
      logic [31:0] payload;
      logic        predicate;
      logic        bypass;
   } CGRAData_32_1_1;

   typedef struct packed {
      logic payload;
      logic predicate;
   } CGRAData_1_1;

   typedef struct packed {
      logic [5:0] ctrl;
      logic [3:0] fu_in;
      logic [5:0] routing;
      logic [7:0] out_routing;
   } CGRAConfig_6_4_6_8;

   localparam int unsigned RF_DATA_W = $bits(CGRAData_32_1_1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DONE  = 2'd2
   } rf_clr_state_e;

   // Width needed to index n items, never less than one bit.
   function automatic int unsigned rf_clog2(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/cgra_rf_wr_resolve.sv
// Write-port arbitration: accepted-write mask, collision flag and per-read-port bypass select.
module cgra_rf_wr_resolve
   import cgra_rf_pkg::*;
#(
   parameter int unsigned NREGS      = 100,
   parameter int unsigned WR_PORTS   = 4,
   parameter int unsigned RD_PORTS   = 4,
   parameter int unsigned ADDR_W     = 7,
   parameter int unsigned SEL_W      = 2,
   parameter bit          CONST_ZERO = 1'b0
) (
   input  logic [WR_PORTS*ADDR_W-1:0]      waddr_i,
   input  logic [WR_PORTS-1:0]             wen_i,
   input  logic                            accept_i,
   input  logic [RD_PORTS*ADDR_W-1:0]      raddr_i,
   output logic [WR_PORTS-1:0]             we_eff_o,
   output logic                            conflict_o,
   output logic [RD_PORTS-1:0]             byp_hit_o,
   output logic [RD_PORTS-1:0][SEL_W-1:0]  byp_sel_o
);

   logic [ADDR_W-1:0] wa [WR_PORTS];

   always_comb begin
      for (int j = 0; j < WR_PORTS; j++) begin
         wa[j] = waddr_i[j*ADDR_W +: ADDR_W];
      end
   end

   // A port loses to any higher-indexed enabled port on the same address; collisions are
   // flagged whether or not the writes would have been accepted.
   always_comb begin
      we_eff_o   = '0;
      conflict_o = 1'b0;
      for (int j = 0; j < WR_PORTS; j++) begin
         we_eff_o[j] = wen_i[j] & accept_i
                       & ({1'b0, wa[j]} < (ADDR_W+1)'(NREGS))
                       & !(CONST_ZERO && (wa[j] == '0));
         for (int k = j + 1; k < WR_PORTS; k++) begin
            if (wen_i[j] && wen_i[k] && (wa[k] == wa[j])) begin
               we_eff_o[j] = 1'b0;
               conflict_o  = 1'b1;
            end
         end
      end
   end

   always_comb begin
      byp_hit_o = '0;
      byp_sel_o = '0;
      for (int i = 0; i < RD_PORTS; i++) begin
         for (int j = 0; j < WR_PORTS; j++) begin
            if (we_eff_o[j] && (wa[j] == raddr_i[i*ADDR_W +: ADDR_W])) begin
               byp_hit_o[i] = 1'b1;
               byp_sel_o[i] = SEL_W'(j);
            end
         end
      end
   end

endmodule

// File: rtl/cgra_multiport_regfile.sv
// Parametrised multi-port CGRA register file with valid bits, collision priority,
// optional write-to-read bypass and a sequential bulk-clear engine.
module cgra_multiport_regfile
   import cgra_rf_pkg::*;
#(
   parameter int unsigned DATA_W     = RF_DATA_W,
   parameter int unsigned NREGS      = 100,
   parameter int unsigned RD_PORTS   = 4,
   parameter int unsigned WR_PORTS   = 4,
   parameter bit          BYPASS     = 1'b0,
   parameter bit          CONST_ZERO = 1'b0,
   localparam int unsigned ADDR_W    = rf_clog2(NREGS)
) (
   input  logic                         clk_i,
   input  logic                         reset_ni,
   input  logic [RD_PORTS*ADDR_W-1:0]   raddr_i,
   output logic [RD_PORTS*DATA_W-1:0]   rdata_o,
   output logic [RD_PORTS-1:0]          rvalid_o,
   input  logic [WR_PORTS*ADDR_W-1:0]   waddr_i,
   input  logic [WR_PORTS*DATA_W-1:0]   wdata_i,
   input  logic [WR_PORTS-1:0]          wen_i,
   input  logic                         clr_req_i,
   output logic                         clr_busy_o,
   output logic                         clr_done_o,
   output logic                         wr_conflict_o
);

   localparam int unsigned SEL_W = rf_clog2(WR_PORTS);

   rf_clr_state_e                  state_q, state_d;
   logic [ADDR_W-1:0]              ptr_q, ptr_d;
   logic                           clr_busy_q, clr_busy_d;
   logic                           clr_done_q, clr_done_d;
   logic                           wr_conflict_q;
   logic [NREGS-1:0]               valid_q;
   logic [DATA_W-1:0]              regs_q [NREGS];
   logic                           accept;
   logic                           conflict;
   logic [WR_PORTS-1:0]            we_eff;
   logic [RD_PORTS-1:0]            byp_hit;
   logic [RD_PORTS-1:0][SEL_W-1:0] byp_sel;
   logic [ADDR_W-1:0]              rd_addr;

   assign accept = (state_q == IDLE);

   cgra_rf_wr_resolve #(
      .NREGS      (NREGS),
      .WR_PORTS   (WR_PORTS),
      .RD_PORTS   (RD_PORTS),
      .ADDR_W     (ADDR_W),
      .SEL_W      (SEL_W),
      .CONST_ZERO (CONST_ZERO)
   ) u_wr_resolve (
      .waddr_i    (waddr_i),
      .wen_i      (wen_i),
      .accept_i   (accept),
      .raddr_i    (raddr_i),
      .we_eff_o   (we_eff),
      .conflict_o (conflict),
      .byp_hit_o  (byp_hit),
      .byp_sel_o  (byp_sel)
   );

   // Clear sweep: one entry per cycle, then a single DONE cycle before returning to IDLE.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      clr_busy_d = 1'b0;
      clr_done_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (clr_req_i) begin
               state_d    = SWEEP;
               ptr_d      = '0;
               clr_busy_d = 1'b1;
            end
         end
         SWEEP: begin
            if (ptr_q == ADDR_W'(NREGS - 1)) begin
               state_d    = DONE;
               clr_done_d = 1'b1;
            end else begin
               ptr_d      = ptr_q + ADDR_W'(1);
               clr_busy_d = 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q       <= IDLE;
         ptr_q         <= '0;
         clr_busy_q    <= 1'b0;
         clr_done_q    <= 1'b0;
         wr_conflict_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         clr_busy_q    <= clr_busy_d;
         clr_done_q    <= clr_done_d;
         wr_conflict_q <= conflict;
      end
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         valid_q <= '0;
      end else begin
         if (state_q == SWEEP) begin
            valid_q[ptr_q] <= 1'b0;
         end
         for (int j = 0; j < WR_PORTS; j++) begin
            if (we_eff[j]) begin
               valid_q[waddr_i[j*ADDR_W +: ADDR_W]] <= 1'b1;
            end
         end
      end
   end

   // Data array carries no reset; the valid bits gate every read.
   always_ff @(posedge clk_i) begin
      for (int j = 0; j < WR_PORTS; j++) begin
         if (we_eff[j]) begin
            regs_q[waddr_i[j*ADDR_W +: ADDR_W]] <= wdata_i[j*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      rdata_o  = '0;
      rvalid_o = '0;
      rd_addr  = '0;
      for (int i = 0; i < RD_PORTS; i++) begin
         rd_addr = raddr_i[i*ADDR_W +: ADDR_W];
         if (({1'b0, rd_addr} < (ADDR_W+1)'(NREGS)) && valid_q[rd_addr]) begin
            rdata_o[i*DATA_W +: DATA_W] = regs_q[rd_addr];
            rvalid_o[i]                 = 1'b1;
         end
         if (CONST_ZERO && (rd_addr == '0)) begin
            rdata_o[i*DATA_W +: DATA_W] = '0;
            rvalid_o[i]                 = 1'b1;
         end
         if (BYPASS && byp_hit[i]) begin
            rdata_o[i*DATA_W +: DATA_W] = wdata_i[32'(byp_sel[i])*DATA_W +: DATA_W];
            rvalid_o[i]                 = 1'b1;
         end
      end
   end

   assign clr_busy_o    = clr_busy_q;
   assign clr_done_o    = clr_done_q;
   assign wr_conflict_o = wr_conflict_q;

endmodule
